// File: rtl/adder_sweep_if.sv
// Control, configuration, adder-operand and result signals of the adder sweep sequencer.
interface adder_sweep_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SETTLE_W = 4,
  parameter int unsigned CNT_W    = 8
);
  logic                start;
  logic                abort;
  logic [WIDTH-1:0]    a_base;
  logic [WIDTH-1:0]    b_base;
  logic [CNT_W-1:0]    num_vec;
  logic [SETTLE_W-1:0] settle_cycles;
  logic [WIDTH-1:0]    adder_sum;
  logic [WIDTH-1:0]    adder_a;
  logic [WIDTH-1:0]    adder_b;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    err_count;
  logic                err_valid;
  logic [WIDTH-1:0]    first_err_a;
  logic [WIDTH-1:0]    first_err_sum;

  modport master (
    output start, abort, a_base, b_base, num_vec, settle_cycles, adder_sum,
    input  adder_a, adder_b, busy, done, err_count, err_valid, first_err_a, first_err_sum
  );

  modport slave (
    input  start, abort, a_base, b_base, num_vec, settle_cycles, adder_sum,
    output adder_a, adder_b, busy, done, err_count, err_valid, first_err_a, first_err_sum
  );
endinterface

// File: rtl/adder_sweep_ctrl.sv
// Sweeps operand vectors through an adder under test, checks each sampled sum
// against a+b and records a saturating error count plus the first failing vector.
module adder_sweep_ctrl #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SETTLE_W = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  adder_sweep_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]    a_base;
    logic [WIDTH-1:0]    b_base;
    logic [CNT_W-1:0]    num_vec;
    logic [SETTLE_W-1:0] settle;
  } cfg_t;

  state_t              state_q, state_d;
  cfg_t                cfg_q, cfg_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic [SETTLE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [WIDTH-1:0]    b_q, b_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                err_valid_q, err_valid_d;
  logic [WIDTH-1:0]    fa_q, fa_d;
  logic [WIDTH-1:0]    fs_q, fs_d;
  logic [WIDTH-1:0]    golden;
  logic                mismatch;

  assign golden   = WIDTH'(a_q + b_q);
  assign mismatch = (bus.adder_sum != golden);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      err_valid_q <= 1'b0;
      fa_q        <= '0;
      fs_q        <= '0;
    end else begin
      cfg_q       <= cfg_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_cnt_q   <= err_cnt_d;
      err_valid_q <= err_valid_d;
      fa_q        <= fa_d;
      fs_q        <= fs_d;
    end
  end

  // Next-state and next-register logic; abort freezes everything except the return to IDLE
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    done_d      = 1'b0;
    err_cnt_d   = err_cnt_q;
    err_valid_d = err_valid_q;
    fa_d        = fa_q;
    fs_d        = fs_q;

    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            cfg_d       = '{a_base:  bus.a_base,
                            b_base:  bus.b_base,
                            num_vec: bus.num_vec,
                            settle:  bus.settle_cycles};
            idx_d       = '0;
            err_cnt_d   = '0;
            err_valid_d = 1'b0;
            fa_d        = '0;
            fs_d        = '0;
            state_d     = (bus.num_vec == '0) ? S_DONE : S_APPLY;
          end
        end
        S_APPLY: begin
          a_d     = WIDTH'(cfg_q.a_base + WIDTH'(idx_q));
          b_d     = cfg_q.b_base;
          cnt_d   = cfg_q.settle;
          state_d = (cfg_q.settle != '0) ? S_SETTLE : S_CHECK;
        end
        S_SETTLE: begin
          cnt_d = cnt_q - SETTLE_W'(1);
          if (cnt_q == SETTLE_W'(1)) state_d = S_CHECK;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (!err_valid_q) begin
              err_valid_d = 1'b1;
              fa_d        = a_q;
              fs_d        = bus.adder_sum;
            end
          end
          idx_d   = idx_q + CNT_W'(1);
          state_d = (idx_d == cfg_q.num_vec) ? S_DONE : S_APPLY;
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d == S_APPLY) || (state_d == S_SETTLE) || (state_d == S_CHECK);
  end

  assign bus.adder_a       = a_q;
  assign bus.adder_b       = b_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err_count     = err_cnt_q;
  assign bus.err_valid     = err_valid_q;
  assign bus.first_err_a   = fa_q;
  assign bus.first_err_sum = fs_q;

endmodule
